split_source2: RTL

- Clocked four-phase conditional split. Mirror of the two-input merge/swap stage.
- Accepts one data token on the input channel and one select token on the control channel.
- Routes the data token to output channel 0 or output channel 1 according to the select bit.
- The other output stays idle. Used wherever a condflow merge needs a matching fork upstream, inside a single-clock region.

---
 rtl/split_source2_pkg.sv | 13 +
 rtl/split_source2_fsm.sv | 61 ++++++
 rtl/split_source2.sv | 85 ++++++++
 3 files changed

// File: rtl/split_source2_pkg.sv
// Shared state encoding and constants for the split_source2 conditional split.
package split_source2_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t ACK  = 2'd2;
    localparam state_t RTZ  = 2'd3;

    localparam int CNT_W = 16;

endpackage

// File: rtl/split_source2_fsm.sv
// Four-phase handshake sequencer for split_source2: state register plus
// registered request/acknowledge outputs.
module split_source2_fsm
    import split_source2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_req,
    input  logic ctl_req,
    input  logic sel,
    input  logic sel_next,
    input  logic out_ack0,
    input  logic out_ack1,
    output logic capture,
    output logic accept,
    output logic ack,
    output logic req0,
    output logic req1
);

    state_t state;
    state_t nxt;
    logic   sel_ack;
    logic   req_next;

    // Acknowledge from the non-selected output never influences the sequence.
    assign sel_ack = sel ? out_ack1 : out_ack0;
    assign capture = (state == IDLE) && in_req && ctl_req;
    assign accept  = (state == REQ) && sel_ack;

    always_comb begin
        // NOTE: nxt is given a default first so every path assigns it and no latch is inferred.
        nxt = state;
        case (state)
            IDLE:    if (capture) nxt = REQ;
            REQ:     if (sel_ack) nxt = ACK;
            ACK:     if (!in_req && !ctl_req) nxt = RTZ;
            RTZ:     if (!sel_ack) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave straight from flops.
    assign req_next = (nxt == REQ) || (nxt == ACK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            req0  <= 1'b0;
            req1  <= 1'b0;
            ack   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= nxt;
            req0  <= req_next && !sel_next;
            req1  <= req_next && sel_next;
            ack   <= (nxt == ACK) || (nxt == RTZ);
        end
    end

endmodule

// File: rtl/split_source2.sv
// Clocked four-phase conditional split: routes one data token to output 0 or 1
// by the select token. Optional per-output transfer counters: SPLIT_SOURCE2_CNT_EN.
module split_source2
    import split_source2_pkg::*;
#(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [N-1:0] d_i,
    input  logic         rctl_i,
    output logic         actl_i,
    input  logic         dctl_i,
    output logic         r0_o,
    input  logic         a0_o,
    output logic [N-1:0] d0_o,
    output logic         r1_o,
    input  logic         a1_o,
    output logic [N-1:0] d1_o
`ifdef SPLIT_SOURCE2_CNT_EN
   ,output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
`endif
);

    logic [N-1:0] dreg;
    logic         sel;
    logic         sel_next;
    logic         capture;
    logic         accept;
    logic         ack;

    // The sequencer needs the post-edge select to decode the request lines.
    assign sel_next = capture ? dctl_i : sel;

    split_source2_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .in_req   (r_i),
        .ctl_req  (rctl_i),
        .sel      (sel),
        .sel_next (sel_next),
        .out_ack0 (a0_o),
        .out_ack1 (a1_o),
        .capture  (capture),
        .accept   (accept),
        .ack      (ack),
        .req0     (r0_o),
        .req1     (r1_o)
    );

    assign a_i    = ack;
    assign actl_i = ack;
    assign d0_o   = dreg;
    assign d1_o   = dreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dreg <= '0;
            sel  <= 1'b0;
        end else if (capture) begin
            dreg <= d_i;
            sel  <= dctl_i;
        end
    end

`ifdef SPLIT_SOURCE2_CNT_EN
    // Counters advance on REQ->ACK and wrap naturally at full scale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_o <= '0;
            cnt1_o <= '0;
        end else if (accept) begin
            if (sel) cnt1_o <= cnt1_o + 1'b1;
            else     cnt0_o <= cnt0_o + 1'b1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
